// File: rtl/vga_frame_capture_writer.sv
// Captures one Avalon-ST video frame (one beat per pixel) into memory through an Avalon-MM write master.
// A beat reaches mm_mem_write one cycle after acceptance; st_ready drops only while the write buffer is full or draining.
module vga_frame_capture_writer #(
  parameter int MM_MEM_ADDR_WIDTH = 32,
  parameter int MM_MEM_DATA_WIDTH = 32,
  parameter int MM_ADDR_WIDTH     = MM_MEM_ADDR_WIDTH,
  parameter int MM_DATA_WIDTH     = MM_MEM_DATA_WIDTH,
  parameter logic [MM_ADDR_WIDTH-1:0] MM_START_ADDRESS = 'h400_0000,
  parameter int WIDTH             = 640,
  parameter int HEIGHT            = 480,
  parameter int FRAME_PIXELS      = WIDTH * HEIGHT,
  parameter int FIFO_DEPTH        = 8,
  parameter int ST_EMPTY_WIDTH    = $clog2(MM_DATA_WIDTH / 8 + 1)
) (
  input  logic                       clk,
  input  logic                       reset,
  output logic                       st_ready,
  input  logic                       st_valid,
  input  logic [MM_DATA_WIDTH-1:0]   st_data,
  input  logic                       st_startofpacket,
  input  logic                       st_endofpacket,
  input  logic [ST_EMPTY_WIDTH-1:0]  st_empty,
  output logic                       mm_mem_write,
  output logic [MM_ADDR_WIDTH-1:0]   mm_mem_address,
  output logic [MM_DATA_WIDTH-1:0]   mm_mem_writedata,
  output logic [MM_DATA_WIDTH/8-1:0] mm_mem_byteenable,
  input  logic                       mm_mem_waitrequest,
  input  logic                       mm_csr_write,
  input  logic                       mm_csr_read,
  input  logic [1:0]                 mm_csr_address,
  input  logic [31:0]                mm_csr_writedata,
  output logic [31:0]                mm_csr_readdata,
  output logic                       mm_csr_waitrequest
);

  localparam int BYTES = MM_DATA_WIDTH / 8;
  localparam int IDX_W = $clog2(FRAME_PIXELS + 1);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam logic [IDX_W-1:0] FP_L = IDX_W'(FRAME_PIXELS);
  localparam logic [ST_EMPTY_WIDTH-1:0] CLOSE_EMPTY = ST_EMPTY_WIDTH'(BYTES);

  typedef enum logic [1:0] {IDLE, WAIT_SOP, CAPTURE, DRAIN} state_t;

  typedef struct packed {
    logic [MM_ADDR_WIDTH-1:0] addr;
    logic [MM_DATA_WIDTH-1:0] data;
  } wr_t;

  state_t                   state, state_nxt;
  logic                     enable, armed, frame_done, short_frame, long_frame;
  logic [31:0]              frame_count;
  logic [MM_ADDR_WIDTH-1:0] csr_base, act_base, act_base_nxt, base_eff;
  logic [IDX_W-1:0]         pix_idx, pix_idx_nxt, idx_eff;
  wr_t                      fifo_mem [FIFO_DEPTH];
  wr_t                      push_dat, head;
  logic [PTR_W:0]           wr_ptr, rd_ptr;
  logic                     fifo_full, fifo_empty, push, pop, accept, data_beat;
  logic                     take_beat, arm_take, set_done, set_short, set_long;

  assign fifo_empty = (wr_ptr == rd_ptr);
  assign fifo_full  = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                      (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);
  assign pop        = !fifo_empty && !mm_mem_waitrequest;
  assign st_ready   = (state == CAPTURE) ? !fifo_full : (state != DRAIN);
  assign accept     = st_valid && st_ready;
  assign data_beat  = (st_empty != CLOSE_EMPTY);

  assign head               = fifo_mem[rd_ptr[PTR_W-1:0]];
  assign mm_mem_write       = !fifo_empty;
  assign mm_mem_address     = fifo_empty ? '0 : head.addr;
  assign mm_mem_writedata   = fifo_empty ? '0 : head.data;
  assign mm_mem_byteenable  = '1;
  assign mm_csr_waitrequest = 1'b0;

  always_comb begin
    state_nxt    = state;
    push         = 1'b0;
    push_dat     = '0;
    pix_idx_nxt  = pix_idx;
    act_base_nxt = act_base;
    idx_eff      = pix_idx;
    base_eff     = act_base;
    take_beat    = 1'b0;
    arm_take     = 1'b0;
    set_done     = 1'b0;
    set_short    = 1'b0;
    set_long     = 1'b0;
    case (state)
      IDLE: begin
        if (enable || armed) begin
          state_nxt = WAIT_SOP;
          arm_take  = armed;
        end
      end
      WAIT_SOP: take_beat = accept && st_startofpacket;
      CAPTURE: begin
        take_beat = accept;
        set_short = accept && st_startofpacket;
      end
      default: begin
        if (fifo_empty) begin
          set_done  = 1'b1;
          state_nxt = enable ? WAIT_SOP : IDLE;
        end
      end
    endcase
    // An SOP beat always restarts the frame at pixel 0 with a freshly sampled base.
    if (take_beat) begin
      if (st_startofpacket) begin
        idx_eff  = '0;
        base_eff = csr_base;
      end
      act_base_nxt = base_eff;
      pix_idx_nxt  = idx_eff;
      state_nxt    = CAPTURE;
      if (data_beat) begin
        if (idx_eff < FP_L) begin
          push          = 1'b1;
          push_dat.addr = base_eff + MM_ADDR_WIDTH'(idx_eff) * MM_ADDR_WIDTH'(BYTES);
          push_dat.data = st_data;
          pix_idx_nxt   = idx_eff + IDX_W'(1);
        end else begin
          set_long = 1'b1;
        end
      end
      if (st_endofpacket) begin
        state_nxt = DRAIN;
        if (pix_idx_nxt < FP_L) set_short = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr[PTR_W-1:0]] <= push_dat;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state           <= IDLE;
      pix_idx         <= '0;
      act_base        <= '0;
      wr_ptr          <= '0;
      rd_ptr          <= '0;
      enable          <= 1'b0;
      armed           <= 1'b0;
      csr_base        <= MM_START_ADDRESS;
      frame_done      <= 1'b0;
      short_frame     <= 1'b0;
      long_frame      <= 1'b0;
      frame_count     <= '0;
      mm_csr_readdata <= '0;
    end else begin
      state    <= state_nxt;
      pix_idx  <= pix_idx_nxt;
      act_base <= act_base_nxt;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (arm_take) armed <= 1'b0;
      if (mm_csr_write) begin
        case (mm_csr_address)
          2'd0: begin
            enable <= mm_csr_writedata[0];
            if (mm_csr_writedata[1]) armed <= 1'b1;
          end
          2'd1: csr_base <= MM_ADDR_WIDTH'(mm_csr_writedata);
          2'd2: begin
            if (mm_csr_writedata[1]) frame_done  <= 1'b0;
            if (mm_csr_writedata[2]) short_frame <= 1'b0;
            if (mm_csr_writedata[3]) long_frame  <= 1'b0;
          end
          default: ;
        endcase
      end
      // Flag sets come after the clears so a same-cycle set wins.
      if (set_done)  frame_done  <= 1'b1;
      if (set_short) short_frame <= 1'b1;
      if (set_long)  long_frame  <= 1'b1;
      if (set_done)  frame_count <= frame_count + 32'd1;
      if (mm_csr_read) begin
        case (mm_csr_address)
          2'd0:    mm_csr_readdata <= {30'd0, armed, enable};
          2'd1:    mm_csr_readdata <= 32'(csr_base);
          2'd2:    mm_csr_readdata <= {28'd0, long_frame, short_frame, frame_done, state != IDLE};
          default: mm_csr_readdata <= frame_count;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_vga_frame_capture_writer.sv
// Directed bench for vga_frame_capture_writer with a 16-pixel frame and a write log taken from the MM port.
module tb_vga_frame_capture_writer;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        st_ready;
  logic        st_valid = 1'b0;
  logic [31:0] st_data = '0;
  logic        st_startofpacket = 1'b0;
  logic        st_endofpacket = 1'b0;
  logic [2:0]  st_empty = '0;
  logic        mm_mem_write;
  logic [31:0] mm_mem_address;
  logic [31:0] mm_mem_writedata;
  logic [3:0]  mm_mem_byteenable;
  logic        mm_mem_waitrequest = 1'b0;
  logic        mm_csr_write = 1'b0;
  logic        mm_csr_read = 1'b0;
  logic [1:0]  mm_csr_address = '0;
  logic [31:0] mm_csr_writedata = '0;
  logic [31:0] mm_csr_readdata;
  logic        mm_csr_waitrequest;

  int n_cmp = 0;
  int n_err = 0;
  int wr_mode = 0;
  int cyc = 0;
  int acc_cnt = 0;
  int wr_cnt = 0;
  int acc0 = 0;
  int wr0 = 0;
  int bp_occ = -1;
  bit bp_arm = 1'b0;
  logic [31:0] wq_addr[$];
  logic [31:0] wq_data[$];

  vga_frame_capture_writer #(.FRAME_PIXELS(16)) dut (
    .clk                (clk),
    .reset              (reset),
    .st_ready           (st_ready),
    .st_valid           (st_valid),
    .st_data            (st_data),
    .st_startofpacket   (st_startofpacket),
    .st_endofpacket     (st_endofpacket),
    .st_empty           (st_empty),
    .mm_mem_write       (mm_mem_write),
    .mm_mem_address     (mm_mem_address),
    .mm_mem_writedata   (mm_mem_writedata),
    .mm_mem_byteenable  (mm_mem_byteenable),
    .mm_mem_waitrequest (mm_mem_waitrequest),
    .mm_csr_write       (mm_csr_write),
    .mm_csr_read        (mm_csr_read),
    .mm_csr_address     (mm_csr_address),
    .mm_csr_writedata   (mm_csr_writedata),
    .mm_csr_readdata    (mm_csr_readdata),
    .mm_csr_waitrequest (mm_csr_waitrequest)
  );

  always #5 clk = ~clk;

  // Slave stall pattern: 0 none, 1 high three cycles of four, 2 always high.
  initial forever begin
    @(posedge clk);
    cyc++;
    #1 mm_mem_waitrequest = (wr_mode == 1) ? ((cyc % 4) != 0) : (wr_mode == 2);
  end

  initial forever begin
    @(negedge clk);
    if (bp_arm && bp_occ < 0 && st_valid && !st_ready)
      bp_occ = (acc_cnt - acc0) - (wr_cnt - wr0);
    if (st_valid && st_ready) acc_cnt++;
    if (mm_mem_write && !mm_mem_waitrequest) begin
      wq_addr.push_back(mm_mem_address);
      wq_data.push_back(mm_mem_writedata);
      wr_cnt++;
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic csr_wr(input logic [1:0] a, input logic [31:0] d);
    mm_csr_write = 1'b1; mm_csr_address = a; mm_csr_writedata = d;
    @(posedge clk); #1;
    mm_csr_write = 1'b0;
  endtask

  task automatic csr_chk(input string tag, input logic [1:0] a, input logic [31:0] exp);
    mm_csr_read = 1'b1; mm_csr_address = a;
    @(posedge clk); #1;
    mm_csr_read = 1'b0;
    check_val(tag, mm_csr_readdata, exp);
  endtask

  task automatic send_beat(input logic [31:0] d, input logic sop, input logic eop, input logic [2:0] emp);
    int n;
    logic acc;
    st_valid = 1'b1; st_data = d; st_startofpacket = sop; st_endofpacket = eop; st_empty = emp;
    acc = 1'b0;
    n = 0;
    while (!acc && n < 300) begin
      @(negedge clk);
      acc = st_ready;
      @(posedge clk); #1;
      n++;
    end
    st_valid = 1'b0; st_startofpacket = 1'b0; st_endofpacket = 1'b0; st_empty = '0;
    if (!acc) check_val("beat_accept_timeout", acc, 1);
  endtask

  task automatic send_pixels(input int first, input int last, input logic [31:0] d0);
    for (int i = first; i <= last; i++) send_beat(d0 + i, i == 0, 1'b0, 3'd0);
  endtask

  task automatic send_close();
    send_beat(32'hDEAD_BEEF, 1'b0, 1'b1, 3'd4);
  endtask

  task automatic check_frame(input string tag, input int n, input logic [31:0] base,
                             input logic [31:0] d0, input bit last);
    int t;
    logic [31:0] ga, gd;
    t = 0;
    while (wq_addr.size() < n && t < 3000) begin
      @(posedge clk); #1;
      t++;
    end
    idle(6);
    check_val({tag, "_nwr"}, (wq_addr.size() >= n), 1);
    for (int i = 0; i < n; i++) begin
      ga = (wq_addr.size() > 0) ? wq_addr.pop_front() : 'x;
      gd = (wq_data.size() > 0) ? wq_data.pop_front() : 'x;
      check_val($sformatf("%s_addr%0d", tag, i), ga, base + 4 * i);
      check_val($sformatf("%s_data%0d", tag, i), gd, d0 + i);
    end
    if (last) check_val({tag, "_extra"}, wq_addr.size(), 0);
  endtask

  initial begin
    @(posedge clk); #1;
    idle(3);
    reset = 1'b0;
    idle(1);

    // Reset state
    check_val("rst_st_ready", st_ready, 1);
    check_val("rst_mm_write", mm_mem_write, 0);
    check_val("rst_mm_addr", mm_mem_address, 0);
    check_val("rst_readdata", mm_csr_readdata, 0);
    check_val("rst_byteenable", mm_mem_byteenable, 4'hF);
    check_val("rst_csr_wait", mm_csr_waitrequest, 0);
    csr_chk("rst_control", 2'd0, 32'h0);
    csr_chk("rst_base", 2'd1, 32'h0400_0000);
    csr_chk("rst_status", 2'd2, 32'h0);
    csr_chk("rst_count", 2'd3, 32'h0);

    // One-shot full frame
    csr_wr(2'd1, 32'h1000);
    csr_wr(2'd0, 32'h2);
    idle(3);
    csr_chk("arm_consumed", 2'd0, 32'h0);
    send_pixels(0, 15, 0);
    send_close();
    check_frame("f1", 16, 32'h1000, 0, 1'b1);
    csr_chk("f1_status", 2'd2, 32'h2);
    csr_chk("f1_count", 2'd3, 32'd1);
    csr_wr(2'd2, 32'hF);
    csr_chk("f1_clr", 2'd2, 32'h0);

    // Same frame against a stalling slave
    wr_mode = 1;
    csr_wr(2'd0, 32'h2);
    idle(3);
    acc0 = acc_cnt;
    wr0 = wr_cnt;
    bp_arm = 1'b1;
    send_pixels(0, 15, 0);
    send_close();
    check_frame("wait", 16, 32'h1000, 0, 1'b1);
    check_val("wait_bp_occupancy", bp_occ, 8);
    wr_mode = 0;
    idle(2);
    csr_wr(2'd2, 32'hF);

    // Non-SOP beats before the frame are dropped
    csr_wr(2'd0, 32'h2);
    idle(3);
    for (int i = 0; i < 5; i++) send_beat(32'hA0 + i, 1'b0, 1'b0, 3'd0);
    idle(4);
    check_val("presop_nowrites", wq_addr.size(), 0);
    send_pixels(0, 15, 0);
    send_close();
    check_frame("presop", 16, 32'h1000, 0, 1'b1);
    csr_chk("presop_count", 2'd3, 32'd3);
    csr_wr(2'd2, 32'hF);

    // Short frame
    csr_wr(2'd0, 32'h2);
    idle(3);
    send_pixels(0, 9, 0);
    send_close();
    check_frame("short", 10, 32'h1000, 0, 1'b1);
    csr_chk("short_status", 2'd2, 32'h6);
    csr_wr(2'd2, 32'hF);

    // Long frame
    csr_wr(2'd0, 32'h2);
    idle(3);
    send_pixels(0, 19, 0);
    send_close();
    check_frame("long", 16, 32'h1000, 0, 1'b1);
    csr_chk("long_status", 2'd2, 32'hA);
    csr_chk("long_count", 2'd3, 32'd5);
    csr_wr(2'd2, 32'hF);

    // Continuous mode, base changed mid-frame
    csr_wr(2'd0, 32'h1);
    idle(3);
    send_pixels(0, 5, 0);
    csr_wr(2'd1, 32'h2000);
    send_pixels(6, 15, 0);
    send_close();
    send_pixels(0, 15, 32'h100);
    send_close();
    check_frame("cont1", 16, 32'h1000, 0, 1'b0);
    check_frame("cont2", 16, 32'h2000, 32'h100, 1'b1);
    csr_chk("cont_count", 2'd3, 32'd7);
    csr_chk("cont_status", 2'd2, 32'h3);
    csr_wr(2'd0, 32'h0);
    csr_wr(2'd0, 32'h2);
    csr_chk("armed_readback", 2'd0, 32'h2);

    // Reset mid-frame under a stalled slave
    wr_mode = 2;
    idle(2);
    send_pixels(0, 6, 0);
    @(negedge clk);
    check_val("pre_rst_mm_write", mm_mem_write, 1);
    check_val("pre_rst_mm_addr", mm_mem_address, 32'h2000);
    @(posedge clk); #1;
    st_valid = 1'b1; st_data = 32'd7; reset = 1'b1;
    @(posedge clk); #1;
    check_val("midrst_mm_write", mm_mem_write, 0);
    check_val("midrst_st_ready", st_ready, 1);
    check_val("midrst_mm_addr", mm_mem_address, 0);
    reset = 1'b0;
    st_valid = 1'b0;
    wr_mode = 0;
    idle(2);
    check_val("midrst_nowrites", wq_addr.size(), 0);
    csr_chk("midrst_status", 2'd2, 32'h0);
    csr_chk("midrst_base", 2'd1, 32'h0400_0000);
    csr_chk("midrst_control", 2'd0, 32'h0);
    csr_chk("midrst_count", 2'd3, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/vga_frame_capture_writer.md
Name: vga_frame_capture_writer

Overview:
- Avalon ST sink that captures one video frame (one beat per pixel) into memory through an Avalon MM write master.
- It is the write-side counterpart of the pixel stream sources. It takes the same packet format (SOP on pixel 0, trailing close beat with EOP and empty = MM_DATA_WIDTH/8) and writes pixels linearly from a CSR-programmed base address.
- Used for frame grab/readback and for DMA-style copies into a frame buffer.

Parameters:
- MM_ADDR_WIDTH, MM_MEM_ADDR_WIDTH: byte address width of the memory master.
- MM_DATA_WIDTH, MM_MEM_DATA_WIDTH: pixel/word width. One beat equals one word.
- MM_START_ADDRESS, 'h400_0000: reset value of the base address register.
- FRAME_PIXELS, WIDTH*HEIGHT: pixels written per frame.
- FIFO_DEPTH, 8: write buffer depth in words. Power of two, at least 2.
- ST_EMPTY_WIDTH, $clog2(MM_DATA_WIDTH/8+1): width of st_empty.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high
- st_ready  out  1  sink ready
- st_valid  in  1  beat valid
- st_data  in  MM_DATA_WIDTH  pixel
- st_startofpacket  in  1  first pixel of frame
- st_endofpacket  in  1  end of frame
- st_empty  in  ST_EMPTY_WIDTH  empty bytes; full-word empty marks a data-less close beat
- mm_mem_write  out  1  write request
- mm_mem_address  out  MM_ADDR_WIDTH  byte address
- mm_mem_writedata  out  MM_DATA_WIDTH  data
- mm_mem_byteenable  out  MM_DATA_WIDTH/8  always all ones
- mm_mem_waitrequest  in  1  slave stall
- mm_csr_write  in  1  CSR write
- mm_csr_read  in  1  CSR read
- mm_csr_address  in  2  word address
- mm_csr_writedata  in  32  CSR write data
- mm_csr_readdata  out  32  CSR read data, valid one cycle after mm_csr_read
- mm_csr_waitrequest  out  1  tied 0

Behaviour:
- Reset values:
  - st_ready=1, mm_mem_write=0, mm_csr_readdata=0.
  - Address/data outputs 0.
  - State IDLE, FIFO empty.
  - Base=MM_START_ADDRESS; all flags and counts 0.
- CSR 0 CONTROL: bit0 continuous enable. Writing bit1=1 arms a one-shot capture; it reads back as the armed flag.
- CSR 1 BASE: byte base address, word aligned. Sampled into the active base only when an SOP beat starts a capture, so mid-frame writes affect the next frame.
- CSR 2 STATUS: bit0 busy (state != IDLE), bit1 frame_done (sticky), bit2 short_frame (sticky), bit3 long_frame (sticky). Writing 1 to a bit clears it.
- CSR 3 COUNT: frames completed, 32-bit, wraps.
- Beat acceptance means st_valid && st_ready.
- FSM:
  - IDLE:
    - st_ready=1; beats are accepted and dropped, so the upstream never stalls.
    - Go to WAIT_SOP when enable=1 or armed=1; arming clears the armed flag.
  - WAIT_SOP:
    - st_ready=1; non-SOP beats are dropped.
    - An accepted SOP beat latches the base, sets pixel index to 0, pushes pixel 0 (if st_ready) and goes to CAPTURE.
  - CAPTURE:
    - st_ready = !fifo_full.
    - Each accepted data beat with index < FRAME_PIXELS pushes {base + index*(MM_DATA_WIDTH/8), data}, then index increments.
    - Data beats with index >= FRAME_PIXELS are dropped and set long_frame.
    - An EOP beat goes to DRAIN. It is written only if it is a data beat (empty != MM_DATA_WIDTH/8). If fewer than FRAME_PIXELS were written, set short_frame.
    - An SOP beat arriving in CAPTURE sets short_frame and restarts at index 0 with that beat, re-latching the base.
  - DRAIN:
    - st_ready=0.
    - When the FIFO is empty and the last write is accepted: set frame_done, increment COUNT, go to WAIT_SOP if enable=1, else IDLE.
- MM master:
  - mm_mem_write = FIFO non-empty, driven from the FIFO head.
  - Pop when !mm_mem_waitrequest. Address and data stay stable while waitrequest is high.
  - Latency: a beat accepted at edge N can be presented on mm_mem_write after edge N+1.
  - Push and pop in the same cycle on a full FIFO is not allowed; ready is based on full only.
- Address arithmetic is modulo 2^MM_ADDR_WIDTH and wraps silently.
- Reset mid-frame:
  - All state is dropped on the next edge; mm_mem_write deasserts even under waitrequest (accepted protocol exception).
  - Pending writes are lost; no counters update.
- Simultaneous CSR status clear and flag set: set wins.

Test Plan:
- FRAME_PIXELS=16, base=0x1000, arm; send SOP + 16 pixels 0..15 + close beat (EOP, empty=4) -> 16 writes to 0x1000..0x103C with data 0..15, frame_done=1, COUNT=1, return to IDLE.
- Same frame with waitrequest high for 3 of every 4 cycles -> st_ready drops when 8 entries are buffered, write order and data unchanged, no beat lost.
- Stream 5 pixels before SOP in WAIT_SOP -> all accepted with no writes; capture begins at the SOP pixel at 0x1000.
- EOP after 10 pixels -> 10 writes, short_frame=1, frame_done=1; 20 pixels then EOP -> 16 writes, long_frame=1.
- enable=1, two back-to-back frames, BASE changed to 0x2000 mid-frame 1 -> frame 1 at 0x1000, frame 2 at 0x2000, COUNT=2.
- Assert reset during pixel 7 with waitrequest high -> next cycle mm_mem_write=0, st_ready=1, STATUS=0, BASE=MM_START_ADDRESS.
